// File: rtl/barrier_gen.sv
// -----------------------------------------------------------------------------
// barrier_gen
//
// Top-of-board barrier source for the cart game. One new 8-bit barrier row is
// produced per sampling period (2^WIDTH cycles) from a 16-bit Galois LFSR.
// The row drives the `in` port of the top row shifter. Spacing and density of
// barriers scale with the selected difficulty level.
//
// Ports:
//   clk    in  1  single clock
//   reset  in  1  synchronous, active-high reset
//   gg     in  1  game over; sampled on ticks, freezes the generator (sticky)
//   level  in  2  difficulty 0 (sparse, widely spaced) .. 3 (dense, every row)
//   out    out 8  barrier row, bit i = barrier in column i
//   rows   out 8  number of barrier rows emitted, saturating at 255
//
// Parameters:
//   WIDTH  phase counter width; must match the shifter chain's WIDTH
//   SEED   LFSR reset value (0 is replaced by 16'h0001)
//
// Optional feature macro: BARRIER_GEN_SAFE_LANE_EN
//   When defined, a row that would be fully blocked (8'hFF) has column
//   lfsr[10:8] cleared so there is always an open lane.
// -----------------------------------------------------------------------------
module barrier_gen #(
    parameter int unsigned WIDTH = 2,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gg,
    input  logic [1:0] level,
    output logic [7:0] out,
    output logic [7:0] rows
);

    // An all-zero Galois LFSR never leaves zero, so a zero seed is replaced.
    localparam logic [15:0] SEED_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
    // x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    typedef enum logic [1:0] {
        WARM = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] incr;
    logic [15:0]      lfsr;
    logic [1:0]       warm_cnt;
    logic [1:0]       gap_cnt;
    logic             tick;
    logic [7:0]       pattern;

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) begin
            n = n ^ LFSR_MASK;
        end
        return n;
    endfunction

    // Blank rows between barrier rows: 3,2,1,0 for levels 0..3.
    function automatic logic [1:0] spacing(input logic [1:0] lv);
        return 2'd3 - lv;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Levels 0-1 AND the two LFSR bytes together for a sparse row; levels
    // 2-3 use the low byte directly.
    function automatic logic [7:0] make_pattern(input logic [15:0] s,
                                                input logic [1:0]  lv);
        logic [7:0] p;
        p = lv[1] ? s[7:0] : (s[7:0] & s[15:8]);
`ifdef BARRIER_GEN_SAFE_LANE_EN
        if (p == 8'hFF) begin
            p[s[10:8]] = 1'b0;
        end
`endif
        return p;
    endfunction

    // -------------------------------------------------------------------------
    // Phase counter: free-running (also in HALT) so ticks stay aligned with
    // the shifter chain, which samples on the same edges.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            incr <= '0;
        end else begin
            incr <= incr + WIDTH'(1);
        end
    end

    assign tick    = (incr == '0) && !reset;
    assign pattern = make_pattern(lfsr, level);

    // -------------------------------------------------------------------------
    // Generator FSM. All state advances only on tick. A tick with gg high
    // enters HALT without touching out/rows/lfsr/gap_cnt.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= WARM;
            warm_cnt <= 2'd0;
            gap_cnt  <= 2'd0;
            lfsr     <= SEED_INIT;
            out      <= 8'h00;
            rows     <= 8'h00;
        end else if (tick) begin
            case (state)
                WARM: begin
                    if (gg) begin
                        state <= HALT;
                    end else begin
                        out      <= 8'h00;
                        lfsr     <= lfsr_step(lfsr);
                        warm_cnt <= warm_cnt + 2'd1;
                        // Fourth warm-up tick: next tick emits the first row.
                        if (warm_cnt == 2'd3) begin
                            state   <= RUN;
                            gap_cnt <= 2'd0;
                        end
                    end
                end
                RUN: begin
                    if (gg) begin
                        state <= HALT;
                    end else begin
                        lfsr <= lfsr_step(lfsr);
                        if (gap_cnt == 2'd0) begin
                            // level is only sampled here, on reload.
                            out     <= pattern;
                            gap_cnt <= spacing(level);
                            rows    <= sat_inc(rows);
                        end else begin
                            out     <= 8'h00;
                            gap_cnt <= gap_cnt - 2'd1;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrier_gen.sv
// -----------------------------------------------------------------------------
// tb_barrier_gen
//
// Self-checking bench for barrier_gen (WIDTH=2, SEED=16'hACE1). A schedule
// model (tick numbers, next emission tick, halted flag) predicts out/rows and
// is compared against the DUT every cycle; hand-computed literals pin both the
// DUT and the model at key points.
// -----------------------------------------------------------------------------
module tb_barrier_gen;

    localparam int unsigned W      = 2;
    localparam int          PERIOD = 4;

    logic       clk;
    logic       reset;
    logic       gg;
    logic [1:0] level;
    logic [7:0] out;
    logic [7:0] rows;

    barrier_gen #(.WIDTH(W), .SEED(16'hACE1)) dut (
        .clk   (clk),
        .reset (reset),
        .gg    (gg),
        .level (level),
        .out   (out),
        .rows  (rows)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: ticks are numbered from the first edge after
    // reset release. Ticks 1-4 are warm-up; the first barrier is at tick 5
    // and each barrier schedules the next one (4 - level) ticks later.
    // ------------------------------------------------------------------
    int          m_cyc;
    int          m_tick;
    int          m_next_emit;
    int          m_rows;
    bit          m_halt;
    logic [15:0] m_lfsr;
    logic [7:0]  m_out;
    logic [7:0]  pu_rows [1:20];
    bit          pu_done = 1'b0;

    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] nxt;
        nxt = {1'b0, s[15:1]};
        if (s[0]) nxt = nxt ^ 16'hB400;
        return nxt;
    endfunction

    function automatic logic [7:0] model_pattern(input logic [15:0] s, input logic [1:0] lv);
        logic [7:0] p;
        if (lv < 2) p = s[7:0] & s[15:8];
        else        p = s[7:0];
`ifdef BARRIER_GEN_SAFE_LANE_EN
        if (p == 8'hFF) p[s[10:8]] = 1'b0;
`endif
        return p;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cyc       = 0;
            m_tick      = 0;
            m_next_emit = 5;
            m_rows      = 0;
            m_halt      = 1'b0;
            m_lfsr      = 16'hACE1;
            m_out       = 8'h00;
        end else begin
            if ((m_cyc % PERIOD) == 0 && !m_halt) begin
                m_tick++;
                if (gg) begin
                    m_halt = 1'b1;
                end else begin
                    if (m_tick == m_next_emit) begin
                        m_out = model_pattern(m_lfsr, level);
                        if (m_rows < 255) m_rows++;
                        m_next_emit = m_tick + 4 - int'(level);
                        if (!pu_done && m_rows <= 20) pu_rows[m_rows] = m_out;
                    end else begin
                        m_out = 8'h00;
                    end
                    m_lfsr = model_step(m_lfsr);
                end
            end
            m_cyc++;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_vs_model", out, m_out);
            check("rows_vs_model", rows, m_rows[7:0]);
        end
    end

    task automatic wait_rows(input int target, input int budget);
        int n;
        logic [7:0] t8;
        n  = 0;
        t8 = target[7:0];
        while (rows !== t8 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_rows: rows=%0d never reached %0d", rows, target);
        end
    endtask

    int base;
    int ff_cnt;

    initial begin
        reset = 1'b1;
        gg    = 1'b0;
        level = 2'd3;
        @(negedge clk);
        chk_en = 1'b1;
        check("reset_out", out, 8'h00);
        check("reset_rows", rows, 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Warm-up: nothing through cycle 16, first barrier at cycle 17.
        repeat (16) @(negedge clk);
        check("warm_out_c16", out, 8'h00);
        check("warm_rows_c16", rows, 8'h00);
        @(negedge clk);
        check("first_out_c17", out, 8'h4E);
        check("first_rows_c17", rows, 8'h01);
        check("model_first_out", m_out, 8'h4E);
        repeat (4) @(negedge clk);
        check("second_out_c21", out, 8'h27);
        check("second_rows_c21", rows, 8'h02);
        repeat (4) @(negedge clk);
        check("third_out_c25", out, 8'h13);
        check("model_third_out", m_out, 8'h13);

        // gg pulse off-tick must be ignored.
        @(negedge clk);
        gg = 1'b1;
        @(negedge clk);
        gg = 1'b0;

        // Reset mid-run at rows=37; replay must match power-up rows.
        wait_rows(37, 200);
        pu_done = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            wait_rows(n, 40);
            check("replay_row", out, pu_rows[n]);
        end

        // Level 3 density up to 64 rows.
        wait_rows(64, 300);

        // Level 0 spacing: barrier then exactly 3 blank rows.
        level = 2'd0;
        base  = m_rows;
        wait_rows(base + 2, 100);
        repeat (4) @(negedge clk);
        check("l0_blank1", out, 8'h00);
        repeat (4) @(negedge clk);
        check("l0_blank2", out, 8'h00);
        repeat (4) @(negedge clk);
        check("l0_blank3", out, 8'h00);
        repeat (4) @(negedge clk);
        check("l0_rows_16cyc", rows, 8'(base + 3));
        wait_rows(base + 20, 400);

        // Game over at rows=10, gg raised mid-period and held over the tick.
        reset = 1'b1;
        level = 2'd3;
        @(negedge clk);
        reset = 1'b0;
        wait_rows(10, 100);
        @(negedge clk);
        gg = 1'b1;
        repeat (4) @(negedge clk);
        gg = 1'b0;
        repeat (40) @(negedge clk);
        check("gg_rows_frozen", rows, 8'd10);
        reset = 1'b1;
        @(negedge clk);
        check("gg_reset_out", out, 8'h00);
        check("gg_reset_rows", rows, 8'h00);
        reset = 1'b0;

        // 1000 rows at level 3 (also drives rows into saturation).
        ff_cnt = 0;
        repeat (4020) begin
            @(negedge clk);
            if (out == 8'hFF) ff_cnt++;
        end
        check("rows_saturated", rows, 8'hFF);
`ifdef BARRIER_GEN_SAFE_LANE_EN
        check("safe_lane_no_ff", (ff_cnt > 255) ? 8'hFF : ff_cnt[7:0], 8'h00);
`endif

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
